regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised successor of the core register file: WIDTH-bit, NREGS entries, two async
//  read ports, two sync write ports (ALU writeback A, load writeback B), optional
//  write-through bypass, per-register busy scoreboard for hazard detection.
//  Top index NREGS-1 is the PC: reads return input r15, never stored. Sits in decode stage.
// PARAMETERS
//  WIDTH   32  data width of every register and data port
//  NREGS   16  architectural registers incl. PC (>=2); AW = $clog2(NREGS) localparam
//  BYPASS  1   1: same-cycle write data forwarded to reads/busy; 0: reads see stored value
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high
//  ra1, ra2   in   AW     read addresses
//  rd1, rd2   out  WIDTH  read data
//  busy1,busy2 out 1      scoreboard busy bit of ra1 / ra2
//  r15        in   WIDTH  PC value (PC+8) returned for address NREGS-1
//  we3        in   1      write enable, port A
//  wa3        in   AW     write address, port A
//  wd3        in   WIDTH  write data, port A
//  we4        in   1      write enable, port B
//  wa4        in   AW     write address, port B
//  wd4        in   WIDTH  write data, port B
//  iss_valid  in   1      instruction issued with a pending destination
//  iss_wa     in   AW     destination of issued instruction
// BEHAVIOUR
//  Storage rf[0..NREGS-2], busy[0..NREGS-2]; all sequential state updates on posedge clk.
//  Reset: all rf <= 0, all busy <= 0; reset dominates every write and issue that cycle.
//   After reset: rdN = 0 (r15 if raN = NREGS-1), busyN = 0.
//  Write: weX & waX < NREGS-1 -> rf[waX] <= wdX next edge. Writes to PC index or
//   address >= NREGS ignored (no state change).
//  Both ports, same address, same cycle: port B (wd4) wins.
//  Read (combinational, zero latency):
//   raN == NREGS-1 -> r15; raN >= NREGS -> 0; else rf[raN].
//   BYPASS=1 and a valid write this cycle hits raN -> that write data (B over A).
//   BYPASS=0 -> stored value; new value visible the cycle after the edge.
//  Scoreboard:
//   iss_valid & iss_wa < NREGS-1 -> busy[iss_wa] <= 1.
//   valid write to addr (either port) -> busy[addr] <= 0.
//   Same-cycle issue and write to same addr: set wins (busy stays 1, newer producer).
//   Issue to PC/out-of-range index ignored.
//   busyN = busy[raN], forced 0 for PC index and raN >= NREGS.
//   BYPASS=1: busyN also 0 when a valid write this cycle hits raN, unless busy was set by
//   a different in-flight issue (i.e. busyN = busy[raN] & ~hit, cleared only by this write).
//  No internal timing paths beyond 1 cycle; read ports have zero latency, writes 1 cycle.
// TESTING
//  reset=1 2 cycles, ra1=0, ra2=15, r15=0x108 -> rd1=0, rd2=0x108, busy1=busy2=0.
//  we3=1 wa3=4 wd3=0xDEADBEEF, ra1=4: BYPASS=1 -> rd1=0xDEADBEEF same cycle;
//   BYPASS=0 -> rd1=0 that cycle, 0xDEADBEEF next cycle.
//  we3=1 wa3=7 wd3=0x11, we4=1 wa4=7 wd4=0x22 same cycle -> rf[7]=0x22 after edge.
//  iss_valid wa=5 -> next cycle ra1=5 busy1=1; we4 wa4=5 wd4=0x55 -> busy1=0 next cycle,
//   rd1=0x55; same-cycle iss_valid wa=5 plus we3 wa3=5 -> busy stays 1.
//  we3=1 wa3=15 wd3=0xFFFF_FFFF; iss_valid wa=15 -> rd for 15 still r15, busy=0, no rf change.
//  Write rf[2]=0xA5 and set busy[2], then reset=1 with we3 wa3=2 wd3=0x3C same cycle
//   -> rf[2]=0, busy[2]=0 after edge.

Source files
------------

// File: rtl/regfile_sb.sv
// Decode-stage register file: two async read ports, two sync write ports, PC alias at the
// top index, optional same-cycle write-through bypass and a per-register busy scoreboard.
module regfile_sb #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 16,
  parameter int BYPASS = 1,
  localparam int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             busy1,
  output logic             busy2,
  input  logic [WIDTH-1:0] r15,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic             we4,
  input  logic [AW-1:0]    wa4,
  input  logic [WIDTH-1:0] wd4,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_wa
);

  localparam int PC = NREGS - 1;

  logic [WIDTH-1:0] rf_q [PC];
  logic [WIDTH-1:0] rf_d [PC];
  logic [PC-1:0]    busy_q;
  logic [PC-1:0]    busy_d;

  // Only indices below the PC alias hold storage; PC and out-of-range addresses never hit.
  function automatic logic stored_addr(input logic [AW-1:0] a);
    return 32'(a) < PC;
  endfunction

  function automatic logic wr_hit(input logic we, input logic [AW-1:0] wa,
                                  input logic [AW-1:0] a);
    return we && stored_addr(wa) && (wa == a);
  endfunction

  always_comb begin
    rf_d   = rf_q;
    busy_d = busy_q;
    for (int i = 0; i < PC; i++) begin
      if (wr_hit(we3, wa3, AW'(i))) begin
        rf_d[i]   = wd3;
        busy_d[i] = 1'b0;
      end
      // Port B is applied last so it wins a same-address collision.
      if (wr_hit(we4, wa4, AW'(i))) begin
        rf_d[i]   = wd4;
        busy_d[i] = 1'b0;
      end
      // A newer producer issuing this cycle keeps the register busy.
      if (wr_hit(iss_valid, iss_wa, AW'(i))) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PC; i++) rf_q[i] <= '0;
      busy_q <= '0;
    end else begin
      rf_q   <= rf_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd1   = '0;
    rd2   = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < PC; i++) begin
      if (ra1 == AW'(i)) begin
        rd1   = rf_q[i];
        busy1 = busy_q[i];
      end
      if (ra2 == AW'(i)) begin
        rd2   = rf_q[i];
        busy2 = busy_q[i];
      end
    end
    if (ra1 == AW'(PC)) rd1 = r15;
    if (ra2 == AW'(PC)) rd2 = r15;
    if (BYPASS != 0) begin
      if (wr_hit(we3, wa3, ra1)) begin rd1 = wd3; busy1 = 1'b0; end
      if (wr_hit(we4, wa4, ra1)) begin rd1 = wd4; busy1 = 1'b0; end
      if (wr_hit(we3, wa3, ra2)) begin rd2 = wd3; busy2 = 1'b0; end
      if (wr_hit(we4, wa4, ra2)) begin rd2 = wd4; busy2 = 1'b0; end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one bypassing and one non-bypassing instance share stimulus.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ra1, ra2, wa3, wa4, iss_wa;
  logic        we3, we4, iss_valid;
  logic [31:0] wd3, wd4, r15;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        busy1_b, busy2_b, busy1_n, busy2_n;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_sb #(.WIDTH(32), .NREGS(16), .BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .busy1(busy1_b), .busy2(busy2_b), .r15(r15),
    .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
    .iss_valid(iss_valid), .iss_wa(iss_wa)
  );

  regfile_sb #(.WIDTH(32), .NREGS(16), .BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
    .busy1(busy1_n), .busy2(busy2_n), .r15(r15),
    .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
    .iss_valid(iss_valid), .iss_wa(iss_wa)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  ra1, ra2;
    logic        we3;  logic [3:0] wa3; logic [31:0] wd3;
    logic        we4;  logic [3:0] wa4; logic [31:0] wd4;
    logic        iv;   logic [3:0] iw;
    logic [31:0] e_rd1b, e_rd1n;
    logic        e_b1b, e_b1n;
    logic [31:0] e_rd2;
    logic        e_b2;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mk(logic rst, logic [3:0] a1, logic [3:0] a2,
                              logic w3, logic [3:0] a3, logic [31:0] d3,
                              logic w4, logic [3:0] a4, logic [31:0] d4,
                              logic iv, logic [3:0] iw,
                              logic [31:0] e1b, logic [31:0] e1n, logic b1b, logic b1n,
                              logic [31:0] e2, logic b2);
    vec_t v;
    v.rst = rst; v.ra1 = a1; v.ra2 = a2;
    v.we3 = w3; v.wa3 = a3; v.wd3 = d3;
    v.we4 = w4; v.wa4 = a4; v.wd4 = d4;
    v.iv = iv; v.iw = iw;
    v.e_rd1b = e1b; v.e_rd1n = e1n; v.e_b1b = b1b; v.e_b1n = b1n;
    v.e_rd2 = e2; v.e_b2 = b2;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    reset = v.rst; ra1 = v.ra1; ra2 = v.ra2;
    we3 = v.we3; wa3 = v.wa3; wd3 = v.wd3;
    we4 = v.we4; wa4 = v.wa4; wd4 = v.wd4;
    iss_valid = v.iv; iss_wa = v.iw;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; we3 = 1'b0; we4 = 1'b0; iss_valid = 1'b0;
    wa3 = '0; wa4 = '0; wd3 = '0; wd4 = '0; iss_wa = '0;
  endtask

  initial begin
    r15 = 32'h108;
    idle_inputs();
    reset = 1'b1; ra1 = '0; ra2 = 4'd15;
    repeat (2) @(posedge clk);
    #1;

    //           rst a1  a2   we3 wa3 wd3           we4 wa4 wd4       iv  iw   rd1 byp       rd1 nobyp     b1b b1n  rd2           b2
    vt[0]  = mk(1, 0,  15,  0, 0, 0,             0, 0, 0,         0, 0,  0,            0,            0, 0,  32'h108,      0);
    vt[1]  = mk(0, 4,  0,   1, 4, 32'hDEADBEEF,  0, 0, 0,         0, 0,  32'hDEADBEEF, 0,            0, 0,  0,            0);
    vt[2]  = mk(0, 4,  15,  0, 0, 0,             0, 0, 0,         0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0,  32'h108,      0);
    vt[3]  = mk(0, 7,  4,   1, 7, 32'h11,        1, 7, 32'h22,    0, 0,  32'h22,       0,            0, 0,  32'hDEADBEEF, 0);
    vt[4]  = mk(0, 7,  7,   0, 0, 0,             0, 0, 0,         0, 0,  32'h22,       32'h22,       0, 0,  32'h22,       0);
    vt[5]  = mk(0, 5,  5,   0, 0, 0,             0, 0, 0,         1, 5,  0,            0,            0, 0,  0,            0);
    vt[6]  = mk(0, 5,  5,   0, 0, 0,             0, 0, 0,         0, 0,  0,            0,            1, 1,  0,            1);
    vt[7]  = mk(0, 5,  3,   0, 0, 0,             1, 5, 32'h55,    0, 0,  32'h55,       0,            0, 1,  0,            0);
    vt[8]  = mk(0, 5,  5,   0, 0, 0,             0, 0, 0,         0, 0,  32'h55,       32'h55,       0, 0,  32'h55,       0);
    vt[9]  = mk(0, 5,  4,   1, 5, 32'h66,        0, 0, 0,         1, 5,  32'h66,       32'h55,       0, 0,  32'hDEADBEEF, 0);
    vt[10] = mk(0, 5,  5,   0, 0, 0,             0, 0, 0,         0, 0,  32'h66,       32'h66,       1, 1,  32'h66,       1);
    vt[11] = mk(0, 15, 4,   1, 15, 32'hFFFFFFFF, 0, 0, 0,         1, 15, 32'h108,      32'h108,      0, 0,  32'hDEADBEEF, 0);
    vt[12] = mk(0, 15, 5,   0, 0, 0,             0, 0, 0,         0, 0,  32'h108,      32'h108,      0, 0,  32'h66,       1);
    vt[13] = mk(0, 0,  4,   1, 2, 32'hA5,        0, 0, 0,         0, 0,  0,            0,            0, 0,  32'hDEADBEEF, 0);
    vt[14] = mk(0, 2,  5,   0, 0, 0,             0, 0, 0,         1, 2,  32'hA5,       32'hA5,       0, 0,  32'h66,       1);
    vt[15] = mk(0, 2,  7,   0, 0, 0,             0, 0, 0,         0, 0,  32'hA5,       32'hA5,       1, 1,  32'h22,       0);
    vt[16] = mk(1, 5,  7,   1, 2, 32'h3C,        0, 0, 0,         1, 2,  32'h66,       32'h66,       1, 1,  32'h22,       0);
    vt[17] = mk(0, 2,  5,   0, 0, 0,             0, 0, 0,         0, 0,  0,            0,            0, 0,  0,            0);

    for (int i = 0; i < 18; i++) begin
      apply(vt[i]);
      @(negedge clk);
      chk("rd1_bypass",   i, rd1_b,          vt[i].e_rd1b);
      chk("rd1_nobypass", i, rd1_n,          vt[i].e_rd1n);
      chk("busy1_bypass", i, 32'(busy1_b),   32'(vt[i].e_b1b));
      chk("busy1_nobyp",  i, 32'(busy1_n),   32'(vt[i].e_b1n));
      chk("rd2_bypass",   i, rd2_b,          vt[i].e_rd2);
      chk("rd2_nobypass", i, rd2_n,          vt[i].e_rd2);
      chk("busy2_bypass", i, 32'(busy2_b),   32'(vt[i].e_b2));
      chk("busy2_nobyp",  i, 32'(busy2_n),   32'(vt[i].e_b2));
      @(posedge clk);
      #1;
    end

    // Issue plus writes from both ports to r9 in one cycle: B data lands, busy stays set.
    idle_inputs();
    ra1 = 4'd9; ra2 = 4'd9;
    we3 = 1'b1; wa3 = 4'd9; wd3 = 32'h0000_1111;
    we4 = 1'b1; wa4 = 4'd9; wd4 = 32'h0000_2222;
    iss_valid = 1'b1; iss_wa = 4'd9;
    @(negedge clk);
    chk("seq_byp_b_wins", 100, rd1_b, 32'h0000_2222);
    chk("seq_nobyp_old",  100, rd1_n, 32'h0);
    chk("seq_byp_busy",   100, 32'(busy1_b), 32'h0);
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    chk("seq_stored_b",   101, rd2_n, 32'h0000_2222);
    chk("seq_busy_kept",  101, 32'(busy2_b), 32'h1);
    chk("seq_busy_kept_n",101, 32'(busy1_n), 32'h1);

    // Out-of-range-free clear: a lone port-A write releases r9 and is then readable.
    @(posedge clk);
    #1;
    we3 = 1'b1; wa3 = 4'd9; wd3 = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    chk("seq_clear_busy", 102, 32'(busy1_b), 32'h0);
    chk("seq_clear_data", 102, rd1_n, 32'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
